// File: rtl/watchdog_pkg.sv
// Shared Q-format constants, averager FSM states and QF saturation used by the
// heartbeat averager and the downstream reciprocal unit.
package watchdog_pkg;

    localparam int QF_W = 32;
    localparam int QF_F = 16;
    localparam logic [QF_W-1:0] TWO_QF = QF_W'(2) << QF_F;
    localparam logic [QF_W-1:0] QF_MAX = {1'b0, {(QF_W-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } avg_state_e;

    // Clamp a non-negative magnitude to the largest positive signed w-bit word.
    function automatic logic [63:0] sat_qf(input logic [63:0] value, input int w);
        logic [63:0] max_val;
        max_val = (64'd1 << (w - 1)) - 64'd1;
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/period_ring_sum.sv
// N-entry ring of heartbeat intervals with a running window sum and fill level.
module period_ring_sum #(
    parameter int CNT_W  = 16,
    parameter int LOG2_N = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      we,
    input  logic [CNT_W-1:0]          sample,
    output logic [CNT_W+LOG2_N-1:0]   sum,
    output logic                      full,
    output logic                      almost_full
);

    localparam int N      = 1 << LOG2_N;
    localparam int SUM_W  = CNT_W + LOG2_N;
    localparam int FILL_W = LOG2_N + 1;

    logic [CNT_W-1:0]  ring [N];
    logic [LOG2_N-1:0] wp;
    logic [FILL_W-1:0] fill;

    // NOTE: the ring is a handful of flops, not a RAM, so it takes the async reset;
    // sum must equal the sum of the entries from the first sample onward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) ring[i] <= '0;
            wp   <= '0;
            fill <= '0;
            sum  <= '0;
        end else if (clr) begin
            for (int i = 0; i < N; i++) ring[i] <= '0;
            wp   <= '0;
            fill <= '0;
            sum  <= '0;
        end else if (we) begin
            ring[wp] <= sample;
            wp       <= wp + 1'b1;
            sum      <= sum + SUM_W'(sample) - SUM_W'(ring[wp]);
            if (!full) fill <= fill + 1'b1;
        end
    end

    assign full        = (fill == FILL_W'(N));
    assign almost_full = (fill == FILL_W'(N - 1));

endmodule

// File: rtl/hb_period_avg.sv
// Heartbeat period averager: measures kick intervals, averages the last N,
// and hands the mean (signed QF) to the reciprocal unit via start/done.
module hb_period_avg
    import watchdog_pkg::*;
#(
    parameter int W      = QF_W,
    parameter int F      = QF_F,
    parameter int LOG2_N = 3,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         kick,
    output logic [W-1:0] x_out,
    output logic         start_calc,
    input  logic         done_in,
    output logic         valid_avg,
    output logic         stall
);

    localparam int SUM_W = CNT_W + LOG2_N;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic             pend;
    avg_state_e       st;
    logic [SUM_W-1:0] sum;
    logic             full;
    logic             almost_full;
    logic             sample_we;
    logic             pend_set;
    logic [63:0]      shifted;
    logic [W-1:0]     qf_val;

    assign sample_we = kick && armed && !clr;
    assign pend_set  = sample_we && (full || almost_full);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (kick) begin
            cnt   <= CNT_W'(1);
            armed <= 1'b1;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign stall = armed && (cnt == CNT_MAX);

    period_ring_sum #(
        .CNT_W (CNT_W),
        .LOG2_N(LOG2_N)
    ) u_ring (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .we         (sample_we),
        .sample     (cnt),
        .sum        (sum),
        .full       (full),
        .almost_full(almost_full)
    );

    assign valid_avg = full;

    // sum / N in QF is sum << (F - LOG2_N); the window never makes it negative.
    assign shifted = 64'(sum) << (F - LOG2_N);
    assign qf_val  = W'(sat_qf(shifted, W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= S_IDLE;
            pend  <= 1'b0;
            x_out <= '0;
        end else begin
            // A fresh sample outranks the consume so no update is ever lost.
            if (clr)                pend <= 1'b0;
            else if (pend_set)      pend <= 1'b1;
            else if (st == S_IDLE)  pend <= 1'b0;

            case (st)
                S_IDLE: begin
                    if (pend && !clr) begin
                        x_out <= qf_val;
                        st    <= S_START;
                    end
                end
                S_START: st <= S_WAIT;
                S_WAIT:  if (done_in) st <= S_IDLE;
                default: st <= S_IDLE;
            endcase
        end
    end

    assign start_calc = (st == S_START);

endmodule

// File: tb/tb_hb_period_avg.sv
// Randomised and directed bench for hb_period_avg; two instances (default and a
// short-counter/high-F variant) share stimulus and an interval-list reference model.
module tb_hb_period_avg;

    localparam int LOG2_N = 3;
    localparam int N      = 8;
    localparam int F_D    = 16;
    localparam int F_S    = 24;
    localparam int MAX_D  = 65535;
    localparam int MAX_S  = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        kick;
    logic        done_in;
    logic [31:0] x_d, x_s;
    logic        sc_d, sc_s, va_d, va_s, st_d, st_s;

    always #5 clk = ~clk;

    hb_period_avg #(.W(32), .F(F_D), .LOG2_N(LOG2_N), .CNT_W(16)) dut_d (
        .clk(clk), .rst_n(rst_n), .clr(clr), .kick(kick), .x_out(x_d),
        .start_calc(sc_d), .done_in(done_in), .valid_avg(va_d), .stall(st_d)
    );

    hb_period_avg #(.W(32), .F(F_S), .LOG2_N(LOG2_N), .CNT_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .kick(kick), .x_out(x_s),
        .start_calc(sc_s), .done_in(done_in), .valid_avg(va_s), .stall(st_s)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: list of measured intervals plus an abstract request tracker.
    int          edge_no   = 0;
    int          last_kick = 0;
    int          nsamp;
    int          out_age;
    int          starts_seen;
    bit          armed, pend, outstanding, start_now;
    int          iv[$];
    logic [31:0] ex_d, ex_s;

    function automatic longint win_sum(input int cmax);
        longint s = 0;
        foreach (iv[i]) s += (iv[i] > cmax) ? cmax : iv[i];
        return s;
    endfunction

    // Mean of the window (s / N) expressed in QF = s * 2^F / N, clamped to int32 max.
    function automatic logic [31:0] to_qf(input longint s, input int f);
        longint v;
        v = (s * (longint'(1) << f)) / N;
        if (v > 64'sd2147483647) return 32'h7fff_ffff;
        return 32'(v);
    endfunction

    task automatic model_reset();
        armed = 0; pend = 0; outstanding = 0; start_now = 0;
        iv.delete(); nsamp = 0; out_age = 0;
        ex_d = '0; ex_s = '0;
    endtask

    task automatic step(input bit k, input bit d, input bit c);
        bit exp_st_d, exp_st_s, exp_va;
        @(negedge clk);
        kick = k; done_in = d; clr = c;
        @(posedge clk);
        edge_no++;
        if (start_now) begin
            start_now = 0; outstanding = 1; out_age = 0;
        end else if (outstanding) begin
            if (d) outstanding = 0;
            else   out_age++;
        end else if (pend && !c) begin
            ex_d = to_qf(win_sum(MAX_D), F_D);
            ex_s = to_qf(win_sum(MAX_S), F_S);
            pend = 0;
            start_now = 1;
        end
        if (c) begin
            armed = 0; iv.delete(); nsamp = 0; pend = 0;
        end else if (k) begin
            if (armed) begin
                iv.push_back(edge_no - last_kick);
                if (iv.size() > N) void'(iv.pop_front());
                nsamp++;
                if (nsamp >= N) pend = 1;
            end
            armed = 1;
            last_kick = edge_no;
        end
        #1;
        exp_va   = (nsamp >= N);
        exp_st_d = armed && (edge_no - last_kick + 1 >= MAX_D);
        exp_st_s = armed && (edge_no - last_kick + 1 >= MAX_S);
        if (sc_d) starts_seen++;
        vectors += 4;
        if ({sc_d, sc_s} !== {start_now, start_now}) begin
            miscompares++;
            $display("FAIL start_calc edge %0d got %b%b want %b", edge_no, sc_d, sc_s, start_now);
        end
        if ({va_d, va_s} !== {exp_va, exp_va}) begin
            miscompares++;
            $display("FAIL valid_avg edge %0d got %b%b want %b", edge_no, va_d, va_s, exp_va);
        end
        if ({st_d, st_s} !== {exp_st_d, exp_st_s}) begin
            miscompares++;
            $display("FAIL stall edge %0d got %b%b want %b%b", edge_no, st_d, st_s, exp_st_d, exp_st_s);
        end
        if ({x_d, x_s} !== {ex_d, ex_s}) begin
            miscompares++;
            $display("FAIL x_out edge %0d got %h/%h want %h/%h", edge_no, x_d, x_s, ex_d, ex_s);
        end
    endtask

    function automatic bit want_done(input int lat);
        return (lat >= 0) && outstanding && (out_age >= lat);
    endfunction

    task automatic run(input int cycles, input int period, input int lat);
        for (int i = 0; i < cycles; i++)
            step(period > 0 && ((i + 1) % period == 0), want_done(lat), 1'b0);
    endtask

    task automatic kick_gap(input int gap, input int lat);
        run(gap - 1, 0, lat);
        step(1'b1, want_done(lat), 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; kick = 1'b0; done_in = 1'b0;
        model_reset();
        #12;
        vectors++;
        if ({x_d, x_s, sc_d, sc_s, va_d, va_s, st_d, st_s} !== 70'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h/%h %b%b%b%b%b%b want all zero",
                     x_d, x_s, sc_d, sc_s, va_d, va_s, st_d, st_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_steady();
        run(900, 100, 10);
        vectors++;
        if ({va_d, va_s} !== 2'b11) begin
            miscompares++;
            $display("FAIL steady_valid got %b%b want 11", va_d, va_s);
        end
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (sc_d !== 1'b1 || x_d !== 32'd6553600 || x_s !== 32'd1677721600) begin
            miscompares++;
            $display("FAIL steady_request got %b %0d/%0d want 1 6553600/1677721600", sc_d, x_d, x_s);
        end
        run(20, 0, 10);
    endtask

    task automatic test_fractional();
        step(1'b0, 1'b0, 1'b1);
        kick_gap(5, 10);
        for (int i = 0; i < 8; i++) kick_gap(100 + (i % 2), 10);
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (sc_d !== 1'b1 || x_d !== 32'd6586368 || x_s !== 32'd1686110208) begin
            miscompares++;
            $display("FAIL fractional got %b %0d/%0d want 1 6586368/1686110208", sc_d, x_d, x_s);
        end
        run(20, 0, 10);
    endtask

    task automatic test_coalesce();
        logic [31:0] latest;
        starts_seen = 0;
        run(500, 100, -1);
        vectors++;
        if (starts_seen !== 1) begin
            miscompares++;
            $display("FAIL coalesce_hold starts got %0d want 1", starts_seen);
        end
        latest = to_qf(win_sum(MAX_D), F_D);
        starts_seen = 0;
        run(30, 0, 0);
        vectors++;
        if (starts_seen !== 1 || x_d !== latest) begin
            miscompares++;
            $display("FAIL coalesce_release starts %0d x %0d want 1 %0d", starts_seen, x_d, latest);
        end
    endtask

    task automatic test_stall();
        step(1'b0, 1'b0, 1'b1);
        kick_gap(3, 5);
        for (int i = 0; i < 8; i++) begin
            run(299, 0, 5);
            vectors++;
            if ({st_d, st_s} !== 2'b01) begin
                miscompares++;
                $display("FAIL stall_set got %b%b want 01", st_d, st_s);
            end
            step(1'b1, want_done(5), 1'b0);
            vectors++;
            if (st_s !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_clear got %b want 0", st_s);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (sc_s !== 1'b1 || x_s !== 32'h7fff_ffff || x_d !== 32'd19660800) begin
            miscompares++;
            $display("FAIL saturate got %b %h/%0d want 1 7fffffff/19660800", sc_s, x_s, x_d);
        end
        run(20, 0, 5);
    endtask

    task automatic test_simultaneous();
        kick_gap(50, -1);
        run(5, 0, -1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if ({sc_d, sc_s} !== 2'b11) begin
            miscompares++;
            $display("FAIL kick_done_restart got %b%b want 11", sc_d, sc_s);
        end
        run(10, 0, 3);
        step(1'b1, 1'b0, 1'b1);
        vectors++;
        if ({va_d, va_s} !== 2'b00) begin
            miscompares++;
            $display("FAIL clr_kick_valid got %b%b want 00", va_d, va_s);
        end
        run(300, 0, 3);
        vectors++;
        if (st_s !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_kick_armed stall got %b want 0", st_s);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int gap, lat;
            if ($urandom_range(0, 14) == 0) step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
            gap = $urandom_range(1, 300);
            lat = $urandom_range(0, 15);
            for (int j = 0; j < gap; j++)
                step(j == gap - 1, want_done(lat) || ($urandom_range(0, 9) == 0), 1'b0);
        end
        run(40, 0, 0);
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 1'b1);
        kick_gap(3, -1);
        for (int i = 0; i < 8; i++) kick_gap(40, -1);
        run(4, 0, -1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({x_d, x_s, sc_d, sc_s, va_d, va_s, st_d, st_s} !== 70'd0) begin
            miscompares++;
            $display("FAIL reset_mid got %h/%h %b%b%b%b%b%b want all zero",
                     x_d, x_s, sc_d, sc_s, va_d, va_s, st_d, st_s);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        starts_seen = 0;
        for (int i = 0; i < N; i++) kick_gap(30, 0);
        vectors++;
        if (starts_seen !== 0 || va_d !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_refill starts %0d valid %b want 0 0", starts_seen, va_d);
        end
        kick_gap(30, 0);
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (sc_d !== 1'b1 || x_d !== 32'd1966080) begin
            miscompares++;
            $display("FAIL reset_first_request got %b %0d want 1 1966080", sc_d, x_d);
        end
        run(10, 0, 0);
    endtask

    initial begin
        test_reset();
        test_steady();
        test_fractional();
        test_coalesce();
        test_stall();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hb_period_avg.md
Name: hb_period_avg

Overview:
Heartbeat period averager that sits directly upstream of the fixed-point reciprocal unit in the watchdog datapath. It measures clk cycles between successive kick pulses and keeps a running sum over the last 2^LOG2_N intervals. It converts the mean period to signed Q(W-F).F and hands it to the reciprocal through a start/done handshake. Stalled heartbeats are flagged when the interval counter saturates.

Parameters:
W, 32, output data width (signed QF word)
F, 16, fractional bits of x_out; LOG2_N <= F is required
LOG2_N, 3, log2 of the averaging window (N = 8 samples)
CNT_W, 16, interval counter width; CNT_MAX = 2^CNT_W-1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
clr  in  1  synchronous clear of measurement state
kick  in  1  heartbeat pulse, one clk wide, synchronous
x_out  out  W  mean period, signed QF, to reciprocal x_in
start_calc  out  1  one-cycle request to reciprocal
done_in  in  1  reciprocal done pulse
valid_avg  out  1  window filled (N samples since reset/clr)
stall  out  1  interval counter reached CNT_MAX

Behaviour:
- Reset values (async, rst_n=0):
  - x_out=0, start_calc=0, valid_avg=0, stall=0.
  - cnt=0, armed=0, pend=0, fill=0, wp=0, sum=0, all ring entries 0.
  - FSM in S_IDLE.
- Interval counter cnt (CNT_W bits):
  - Increments every cycle and saturates at CNT_MAX.
  - On kick, cnt loads 1.
  - stall=1 while cnt==CNT_MAX and armed; stall clears on the next kick.
- First kick after reset/clr only sets armed; no sample is taken.
- Each subsequent kick, on the same edge:
  - sample = cnt, which is the cycles since the previous kick and equals CNT_MAX if saturated.
  - sum <= sum + sample - ring[wp]; ring[wp] <= sample.
  - wp wraps modulo N.
  - fill increments, saturating at N.
  - sum width is CNT_W+LOG2_N and never overflows.
- valid_avg=1 once fill==N. pend is set on every sample taken while valid_avg (including the Nth sample).
- FSM, states S_IDLE, S_START, S_WAIT:
  - S_IDLE: if pend, latch x_out <= sat(sum << (F-LOG2_N)), clear pend, go to S_START.
  - S_START: start_calc=1 for exactly this cycle; go to S_WAIT.
  - S_WAIT: x_out held stable; on done_in go to S_IDLE.
- start_calc is decoded from state (st==S_START).
- Latency: kick sampled at edge k, then x_out valid after edge k+1, then start_calc high in the cycle after edge k+1.
- Saturation: if the shifted sum exceeds 2^(W-1)-1, x_out = 2^(W-1)-1. x_out is always > 0 once valid, so the reciprocal never reports invalid for a real sample.
- Samples arriving during S_START/S_WAIT still update ring/sum and set pend.
  - Multiple pending samples coalesce into one request.
  - The next request after done_in uses the latest sum.
- kick and done_in in the same cycle: both take effect. The sample updates sum/pend; the FSM goes to S_IDLE and issues the new request next cycle.
- done_in outside S_WAIT is ignored.
- clr:
  - Zeros cnt, armed, fill, wp, sum, ring, pend, stall and valid_avg.
  - Does not abort S_WAIT: the FSM still waits for done_in, and x_out is held.
  - clr dominates a kick in the same cycle.
- rst_n mid-operation aborts everything immediately to the reset values. The downstream unit must be reset by the same rst_n.

Decomposition:
- watchdog_pkg holds:
  - Q-format constants: W, F, TWO_QF, QF_MAX = 2^(W-1)-1.
  - The avg FSM state enum (S_IDLE, S_START, S_WAIT).
  - The QF saturation function shared with the reciprocal.
- One sub-module, period_ring_sum, covers the N-entry ring, wp, fill and running sum.
  - Inputs: sample, we, clr.
  - Outputs: sum, full.
- The FSM, counter and conversion stay in hb_period_avg.

Test Plan:
- Steady rate: defaults, 9 kicks every 100 cycles -> valid_avg rises on the 9th kick. start_calc pulses 2 edges later with x_out=100<<16=6553600. The bench returns done_in 10 cycles later -> FSM back to S_IDLE.
- Fractional mean: 8 samples alternating 100/101 -> x_out=6586368 (100.5 in Q16.16).
- Coalescing: done_in withheld for 500 cycles while kicks arrive every 100 -> x_out stays constant during S_WAIT. Exactly one further start_calc follows done_in, carrying the latest sum.
- Stall and saturation: after arming, no kick for 65535 cycles -> stall=1. Eight such saturated samples -> x_out=0x7FFFFFFF. The next kick clears stall.
- Simultaneous events: kick in the same cycle as done_in -> new start_calc exactly 2 cycles later. clr with kick -> armed=0, valid_avg=0, no pend.
- Reset mid-S_WAIT: assert rst_n=0 -> all outputs 0 asynchronously. After release, no start_calc until N+1 new kicks.
